instr_encoder: RTL

Streaming LEGv8 instruction encoder, the inverse of the immediate/sign-extension path. It packs an opcode, register numbers and a 64-bit immediate into a 32-bit instruction word for any of the R, I, D, B, CB or IW formats. It range-checks each immediate and buffers results in a 2-entry output skid queue with valid/ready handshakes on both sides. It sits between the debug/boot loader command path and the instruction-memory write port.

---
 rtl/instr_encoder_pkg.sv | 31 +++
 rtl/instr_encoder_skid_fifo.sv | 63 ++++++
 rtl/instr_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the LEGv8 instruction encoder: format codes, immediate bounds, queue sizing.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_D  = 3'd2,
      FMT_B  = 3'd3,
      FMT_CB = 3'd4,
      FMT_IW = 3'd5
   } fmt_e;

   localparam int QUEUE_DEPTH = 2;
   localparam int COUNT_W     = 2;
   localparam int ENTRY_W     = 33;

   localparam logic [63:0]        I_IMM_MAX  = 64'd4095;
   localparam logic [63:0]        IW_IMM_MAX = 64'd65535;
   localparam logic signed [63:0] D_IMM_MIN  = -64'sd256;
   localparam logic signed [63:0] D_IMM_MAX  = 64'sd255;
   localparam int                 B_OFS_MSB  = 27;
   localparam int                 CB_OFS_MSB = 20;

   // True when every bit above msb replicates bit msb (value fits a signed field).
   function automatic logic fits_signed(input logic [63:0] v, input int msb);
      logic [63:0] hi;
      hi = $signed(v) >>> msb;
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_skid_fifo.sv
// Two-entry {instr, err} output queue; entry 0 is the head and drives dout directly.
module instr_enc_skid_fifo
   import instr_encoder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic [COUNT_W-1:0] count
);

   logic [ENTRY_W-1:0] mem_reg [QUEUE_DEPTH];
   logic [COUNT_W-1:0] count_reg;
   logic [COUNT_W-1:0] count_next;
   logic [COUNT_W-1:0] wr_idx;

   // A pop shifts entries toward the head, so the write slot moves down with it.
   assign wr_idx = count_reg - {{(COUNT_W-1){1'b0}}, pop};

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   generate
      for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
         logic [ENTRY_W-1:0] shift_in;
         if (gi + 1 < QUEUE_DEPTH) begin : g_mid
            assign shift_in = mem_reg[gi+1];
         end else begin : g_tail
            assign shift_in = '0;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_reg[gi] <= '0;
            end else if (push && (wr_idx == COUNT_W'(gi))) begin
               mem_reg[gi] <= din;
            end else if (pop) begin
               mem_reg[gi] <= shift_in;
            end
         end
      end
   endgenerate

   assign dout  = mem_reg[0];
   assign count = count_reg;

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 R/I/D/B/CB/IW instruction encoder with immediate range checks and a 2-deep output queue.
// Optional build macro ENC_ALIGN_CHECK_EN flags B/CB byte offsets that are not word aligned.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iValid,
   output logic        oReadyIn,
   input  logic [2:0]  iFormat,
   input  logic [10:0] iOpcode,
   input  logic [4:0]  iRd,
   input  logic [4:0]  iRn,
   input  logic [4:0]  iRm,
   input  logic [5:0]  iShamt,
   input  logic [63:0] iImm,
   output logic        oValid,
   input  logic        iReady,
   output logic        oInstr_unused_guard_n,
   output logic [31:0] oInstr,
   output logic        oRangeErr,
   output logic [15:0] oErrCount
);

   logic [31:0]        word;
   logic               word_err;
   logic               align_err;
   logic               push;
   logic               pop;
   logic               run_reg;
   logic [15:0]        err_count_reg;
   logic [ENTRY_W-1:0] head;
   logic [COUNT_W-1:0] count;

`ifdef ENC_ALIGN_CHECK_EN
   assign align_err = (iImm[1:0] != 2'b00);
`else
   assign align_err = 1'b0;
`endif

   always_comb begin
      word     = '0;
      word_err = 1'b0;
      case (iFormat)
         FMT_R: begin
            word = {iOpcode, iRm, iShamt, iRn, iRd};
         end
         FMT_I: begin
            word     = {iOpcode[10:1], iImm[11:0], iRn, iRd};
            word_err = (iImm > I_IMM_MAX);
         end
         FMT_D: begin
            word     = {iOpcode, iImm[8:0], 2'b00, iRn, iRd};
            word_err = ($signed(iImm) < D_IMM_MIN) || ($signed(iImm) > D_IMM_MAX);
         end
         FMT_B: begin
            word     = {iOpcode[10:5], iImm[27:2]};
            word_err = !fits_signed(iImm, B_OFS_MSB) || align_err;
         end
         FMT_CB: begin
            word     = {iOpcode[10:3], iImm[20:2], iRd};
            word_err = !fits_signed(iImm, CB_OFS_MSB) || align_err;
         end
         FMT_IW: begin
            word     = {iOpcode[10:2], iShamt[1:0], iImm[15:0], iRd};
            word_err = (iImm > IW_IMM_MAX);
         end
         default: begin
            word     = '0;
            word_err = 1'b1;
         end
      endcase
   end

   // Holds oReadyIn low through reset and releases it on the first edge afterwards.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         run_reg <= 1'b0;
      end else begin
         run_reg <= 1'b1;
      end
   end

   assign oReadyIn = run_reg && (count < COUNT_W'(QUEUE_DEPTH));
   assign oValid   = (count != '0);
   assign push     = iValid && oReadyIn;
   assign pop      = oValid && iReady;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         err_count_reg <= '0;
      end else if (push && word_err && (err_count_reg != 16'hFFFF)) begin
         err_count_reg <= err_count_reg + 16'd1;
      end
   end

   instr_enc_skid_fifo u_fifo (
      .clk   (iCLK),
      .rst   (iRST),
      .push  (push),
      .pop   (pop),
      .din   ({word, word_err}),
      .dout  (head),
      .count (count)
   );

   assign oInstr                = head[ENTRY_W-1:1];
   assign oRangeErr             = head[0];
   assign oErrCount             = err_count_reg;
   assign oInstr_unused_guard_n = 1'b1;

endmodule
